// File: rtl/mem_uart_pkg.sv
// Shared state encoding and sizing helpers for the memory-to-UART dumper.
package mem_uart_pkg;

    // Byte index width; covers up to 8 bytes per word (WORD_W = 64).
    localparam int unsigned IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LATCH   = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        CSUM    = 3'd5,
        FIN     = 3'd6
    } state_t;

    function automatic int unsigned bytes_per_word(input int unsigned word_w);
        return word_w / 8;
    endfunction

endpackage

// File: rtl/mem_uart_dumper_if.sv
// Control, ROM and UART-transmitter signals of the memory dumper.
// The slave modport is the dumper; the master modport is whatever drives it.
interface mem_uart_dumper_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 13
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [7:0]        tx_byte;
    logic              tx_send;
    logic              tx_done;

    modport slave (
        input  start, base_addr, word_count, mem_rdata, tx_done,
        output busy, done, mem_addr, tx_byte, tx_send
    );

    modport master (
        output start, base_addr, word_count, mem_rdata, tx_done,
        input  busy, done, mem_addr, tx_byte, tx_send
    );
endinterface

// File: rtl/mem_uart_bytesel.sv
// Picks one byte lane out of a memory word; BIG_ENDIAN reverses lane order.
module mem_uart_bytesel
    import mem_uart_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [7:0]        sel_byte_c
);
    localparam int unsigned BPW = bytes_per_word(WORD_W);

    logic [IDX_W-1:0] lane;

    always_comb begin
        lane       = BIG_ENDIAN ? (IDX_W'(BPW - 1) - idx) : idx;
        sel_byte_c = 8'h00;
        for (int unsigned i = 0; i < BPW; i++) begin
            if (lane == IDX_W'(i)) begin
                sel_byte_c = word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_uart_dumper.sv
// Streams word_count ROM words starting at base_addr out to a UART, byte by byte.
// Optional MEM_UART_CHECKSUM_EN appends a byte making the mod-256 sum of the stream zero.
module mem_uart_dumper
    import mem_uart_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic             clk,
    input  logic             rst,
    mem_uart_dumper_if.slave bus
);
    localparam int unsigned      BPW      = bytes_per_word(WORD_W);
    localparam int unsigned      CNT_W    = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

`ifdef MEM_UART_CHECKSUM_EN
    localparam state_t TAIL_ST = CSUM;
`else
    localparam state_t TAIL_ST = FIN;
`endif

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic              busy_q;
    logic              done_q;
    logic              tx_send_q;
    logic [7:0]        tx_byte_q;

    logic [7:0] sel_byte_c;
    logic [7:0] neg_sum_c;
    logic       csum_phase_c;
    logic       last_byte_c;
    logic       more_words_c;
    logic       data_done_c;

    logic       capture_c;
    logic       latch_c;
    logic       next_byte_c;
    logic       next_word_c;
    logic       busy_d;
    logic       done_d;
    logic       tx_send_d;
    logic [7:0] tx_byte_d;

`ifdef MEM_UART_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       csum_phase_q;
    logic       accum_c;
    logic       arm_csum_c;

    assign csum_phase_c = csum_phase_q;
    assign neg_sum_c    = 8'(8'h00 - sum_q);
`else
    assign csum_phase_c = 1'b0;
    assign neg_sum_c    = 8'h00;
`endif

    mem_uart_bytesel #(
        .WORD_W     (WORD_W),
        .BIG_ENDIAN (BIG_ENDIAN != 0)
    ) u_bytesel (
        .word       (word_q),
        .idx        (idx_q),
        .sel_byte_c (sel_byte_c)
    );

    assign last_byte_c  = (idx_q == LAST_IDX);
    assign more_words_c = (cnt_q != CNT_W'(1));
    // The checksum byte's tx_done must not touch the word/byte bookkeeping.
    assign data_done_c  = (state == WAIT_TX) && bus.tx_done && !csum_phase_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.word_count == '0) ? TAIL_ST : FETCH;
                end
            end
            FETCH:   state_next = LATCH;
            LATCH:   state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: begin
                if (bus.tx_done) begin
                    if (csum_phase_c) begin
                        state_next = FIN;
                    end else if (!last_byte_c) begin
                        state_next = SEND;
                    end else if (more_words_c) begin
                        state_next = FETCH;
                    end else begin
                        state_next = TAIL_ST;
                    end
                end
            end
`ifdef MEM_UART_CHECKSUM_EN
            CSUM:    state_next = SEND;
`endif
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath-control decode
    always_comb begin
        capture_c   = 1'b0;
        latch_c     = 1'b0;
        next_byte_c = 1'b0;
        next_word_c = 1'b0;
        done_d      = 1'b0;
        tx_send_d   = 1'b0;
        tx_byte_d   = tx_byte_q;
`ifdef MEM_UART_CHECKSUM_EN
        accum_c     = 1'b0;
        arm_csum_c  = 1'b0;
`endif
        case (state)
            IDLE:    capture_c = bus.start;
            LATCH:   latch_c   = 1'b1;
            SEND: begin
                tx_send_d = 1'b1;
                tx_byte_d = csum_phase_c ? neg_sum_c : sel_byte_c;
`ifdef MEM_UART_CHECKSUM_EN
                accum_c   = !csum_phase_q;
`endif
            end
            WAIT_TX: begin
                next_byte_c = data_done_c && !last_byte_c;
                next_word_c = data_done_c && last_byte_c;
            end
`ifdef MEM_UART_CHECKSUM_EN
            CSUM:    arm_csum_c = 1'b1;
`endif
            FIN:     done_d = 1'b1;
            default: ;
        endcase
        // busy covers every cycle the FSM is away from IDLE, so it falls with done.
        busy_d = (state_next != IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_send_q <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            if (capture_c) begin
                addr_q <= bus.base_addr;
                cnt_q  <= bus.word_count;
            end
            if (latch_c) begin
                word_q <= bus.mem_rdata;
                idx_q  <= '0;
            end
            if (next_byte_c) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (next_word_c) begin
                cnt_q  <= cnt_q - CNT_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
            busy_q    <= busy_d;
            done_q    <= done_d;
            tx_send_q <= tx_send_d;
            tx_byte_q <= tx_byte_d;
        end
    end

`ifdef MEM_UART_CHECKSUM_EN
    // Running checksum over data bytes only
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q        <= 8'h00;
            csum_phase_q <= 1'b0;
        end else begin
            if (capture_c) begin
                sum_q        <= 8'h00;
                csum_phase_q <= 1'b0;
            end
            if (accum_c) begin
                sum_q <= sum_q + sel_byte_c;
            end
            if (arm_csum_c) begin
                csum_phase_q <= 1'b1;
            end
        end
    end
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_addr = addr_q;
    assign bus.tx_send  = tx_send_q;
    assign bus.tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_mem_uart_dumper.sv
// Drives a little- and a big-endian dumper side by side from one ROM image and
// compares each transmitted byte against a queue built from the ROM contents.
`timescale 1ns/1ps
module tb_mem_uart_dumper;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned BPW    = WORD_W / 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              tx_done;
    logic [WORD_W-1:0] rom [DEPTH];

    logic [7:0] exp_le [$];
    logic [7:0] exp_be [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_uart_dumper_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) if_le ();
    mem_uart_dumper_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) if_be ();

    assign if_le.start      = start;
    assign if_le.base_addr  = base_addr;
    assign if_le.word_count = word_count;
    assign if_le.tx_done    = tx_done;
    assign if_be.start      = start;
    assign if_be.base_addr  = base_addr;
    assign if_be.word_count = word_count;
    assign if_be.tx_done    = tx_done;

    // Synchronous ROM: one cycle of read latency
    always @(posedge clk) begin
        if_le.mem_rdata <= rom[if_le.mem_addr];
        if_be.mem_rdata <= rom[if_be.mem_addr];
    end

    mem_uart_dumper #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .BIG_ENDIAN(0)) dut_le (
        .clk (clk),
        .rst (rst),
        .bus (if_le)
    );

    mem_uart_dumper #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .BIG_ENDIAN(1)) dut_be (
        .clk (clk),
        .rst (rst),
        .bus (if_be)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected byte stream from the ROM image, wrapping addresses modulo DEPTH
    task automatic build_expect(input int base, input int count);
        logic [WORD_W-1:0] word;
        int sum;
        sum = 0;
        exp_le.delete();
        exp_be.delete();
        for (int w = 0; w < count; w++) begin
            word = rom[ADDR_W'((base + w) % DEPTH)];
            for (int k = 0; k < BPW; k++) begin
                exp_le.push_back(8'(word >> (8 * k)));
                exp_be.push_back(8'(word >> (8 * (BPW - 1 - k))));
                sum += int'(8'(word >> (8 * k)));
            end
        end
`ifdef MEM_UART_CHECKSUM_EN
        exp_le.push_back(8'(256 - (sum % 256)));
        exp_be.push_back(8'(256 - (sum % 256)));
`endif
    endtask

    task automatic run_dump(input int base, input int count, input int max_gap, input bit stall);
        int         cyc;
        int         got;
        int         gap;
        int         bad_send;
        int         bad_hold;
        bit         fin;
        logic [7:0] held;
        build_expect(base, count);
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        word_count = (ADDR_W + 1)'(count);
        step();
        start = 1'b0;
        cyc   = 1;
        got   = 0;
        fin   = 1'b0;
        check_eq("busy_after_start", 64'({if_le.busy, if_be.busy}), 64'(2'b11));
        while (!fin && cyc < 4000) begin
            if (if_le.done || if_be.done) begin
                fin = 1'b1;
                check_eq("done_both", 64'({if_le.done, if_be.done}), 64'(2'b11));
                check_eq("busy_at_done", 64'({if_le.busy, if_be.busy}), 64'(2'b00));
                check_eq("byte_total", 64'(got), 64'(exp_le.size()));
`ifndef MEM_UART_CHECKSUM_EN
                if (count == 0) check_eq("empty_done_latency", 64'(cyc), 64'(2));
`endif
            end else if (if_le.tx_send || if_be.tx_send) begin
                check_eq("send_both", 64'({if_le.tx_send, if_be.tx_send}), 64'(2'b11));
                if (got < exp_le.size()) begin
                    check_eq("byte_le", 64'(if_le.tx_byte), 64'(exp_le[got]));
                    check_eq("byte_be", 64'(if_be.tx_byte), 64'(exp_be[got]));
                end else begin
                    check_eq("send_count", 64'(got + 1), 64'(exp_le.size()));
                end
                got++;
                held     = if_le.tx_byte;
                bad_send = 0;
                bad_hold = 0;
                gap      = (stall && got == 1) ? 1000 : int'($urandom_range(max_gap, 1));
                for (int g = 0; g < gap; g++) begin
                    // A start while busy carries a different job that must be ignored
                    if (stall && g == 2) begin
                        start      = 1'b1;
                        base_addr  = ADDR_W'(base + 7);
                        word_count = (ADDR_W + 1)'(9);
                    end else begin
                        start = 1'b0;
                    end
                    step();
                    cyc++;
                    if (if_le.tx_send || if_be.tx_send) bad_send++;
                    if (if_le.tx_byte != held) bad_hold++;
                end
                start = 1'b0;
                check_eq("no_send_in_flight", 64'(bad_send), 64'(0));
                check_eq("tx_byte_stable", 64'(bad_hold), 64'(0));
                tx_done = 1'b1;
                step();
                tx_done = 1'b0;
                cyc++;
            end else begin
                step();
                cyc++;
            end
        end
        if (!fin) check_eq("done_timeout", 64'(cyc), 64'(0));
        step();
        check_eq("done_one_cycle", 64'({if_le.done, if_be.done}), 64'(2'b00));
    endtask

    task automatic wait_send(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (if_le.tx_send) seen = 1'b1;
            else step();
        end
    endtask

    // Reset during the second byte, then a stray tx_done: nothing may follow
    task automatic run_abort();
        bit s1;
        bit s2;
        int n_done;
        int n_send;
        int n_busy;
        start      = 1'b1;
        base_addr  = ADDR_W'(3);
        word_count = (ADDR_W + 1)'(2);
        step();
        start = 1'b0;
        wait_send(s1);
        check_eq("abort_first_send", 64'(s1), 64'(1));
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        wait_send(s2);
        check_eq("abort_second_send", 64'(s2), 64'(1));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_ctrl", 64'({if_le.busy, if_le.done, if_le.tx_send, if_be.busy}), 64'(0));
        check_eq("abort_tx_byte", 64'({if_le.tx_byte, if_be.tx_byte}), 64'(0));
        check_eq("abort_mem_addr", 64'({if_le.mem_addr, if_be.mem_addr}), 64'(0));
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n_done = 0;
        n_send = 0;
        n_busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (if_le.done || if_be.done) n_done++;
            if (if_le.tx_send || if_be.tx_send) n_send++;
            if (if_le.busy || if_be.busy) n_busy++;
            step();
        end
        check_eq("abort_no_done", 64'(n_done), 64'(0));
        check_eq("abort_no_send", 64'(n_send), 64'(0));
        check_eq("abort_idle", 64'(n_busy), 64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        tx_done    = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        rom[0]  = 32'h0F1E2D3C;
        rom[3]  = 32'h01020304;
        rom[5]  = 32'h11223344;
        rom[15] = 32'hA5B6C7D8;
        repeat (3) step();
        check_eq("reset_ctrl", 64'({if_le.busy, if_le.done, if_le.tx_send,
                                    if_be.busy, if_be.done, if_be.tx_send}), 64'(0));
        check_eq("reset_tx_byte", 64'({if_le.tx_byte, if_be.tx_byte}), 64'(0));
        check_eq("reset_mem_addr", 64'({if_le.mem_addr, if_be.mem_addr}), 64'(0));
        rst = 1'b0;
        step();

        run_dump(5, 1, 3, 1'b0);
        run_dump(15, 2, 2, 1'b0);
        run_dump(0, 0, 1, 1'b0);
        run_dump(3, 1, 2, 1'b0);
        run_dump(7, 3, 2, 1'b1);
        run_abort();
        run_dump(9, 2, 3, 1'b0);
        for (int t = 0; t < 20; t++) begin
            rom[$urandom_range(DEPTH - 1, 0)] = $urandom;
            run_dump(int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(5, 0)),
                     int'($urandom_range(4, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_uart_dumper.md
MEM_UART_DUMPER -- requirements
Module: mem_uart_dumper

Interface
REQ-001 SHALL have parameter WORD_W, default 32, memory word width in bits, legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter ADDR_W, default 13, word-address width.
REQ-003 SHALL have parameter BIG_ENDIAN, default 0; 0 sends LSB byte first, 1 sends MSB byte first.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have port start in 1, a one-cycle request to begin a dump, sampled only in IDLE.
REQ-006 SHALL have port base_addr in ADDR_W, the first word address, captured on an accepted start.
REQ-007 SHALL have port word_count in ADDR_W+1, the number of words to send, captured on an accepted start.
REQ-008 SHALL have port busy out 1, high from the cycle after an accepted start until done.
REQ-009 SHALL have port done out 1, a one-cycle pulse when the dump completes.
REQ-010 SHALL have port mem_addr out ADDR_W, the word address to the synchronous ROM.
REQ-011 SHALL have port mem_rdata in WORD_W, ROM data valid exactly 1 cycle after mem_addr is presented.
REQ-012 SHALL have port tx_byte out 8, the byte to the UART transmitter.
REQ-013 SHALL have port tx_send out 1, a one-cycle transmit strobe.
REQ-014 SHALL have port tx_done in 1, a one-cycle pulse from the transmitter at the end of the stop bit.

Function
REQ-015 SHALL implement states IDLE, FETCH, LATCH, SEND, WAIT_TX, CSUM, and FIN.
REQ-016 SHALL move from IDLE to FETCH on start with word_count != 0, and from IDLE to FIN on start with word_count == 0, so that done pulses 2 cycles after start and no byte is sent.
REQ-017 In FETCH, SHALL drive mem_addr to the current address, then go to LATCH.
REQ-018 In LATCH, SHALL register mem_rdata into a word buffer, clear the byte index, then go to SEND.
REQ-019 In SEND, SHALL drive tx_byte from the buffer at the byte index, ordered per BIG_ENDIAN, pulse tx_send for exactly 1 cycle, then go to WAIT_TX.
REQ-020 In WAIT_TX, SHALL hold tx_byte stable until tx_done arrives, and SHALL ignore tx_done in every other state.
REQ-021 On tx_done with bytes remaining in the word, SHALL increment the byte index and go to SEND.
REQ-022 On tx_done after the last byte of the word (index WORD_W/8-1), SHALL decrement the remaining count, increment the address, and go to FETCH if words remain, else to CSUM (macro defined) or FIN.
REQ-023 SHALL increment the address modulo 2^ADDR_W, so that all-ones wraps to 0 with no error.
REQ-024 SHALL assert tx_send at most once per tx_done, so that no strobe is issued while a byte is in flight.
REQ-025 In FIN, SHALL pulse done, drop busy in the same cycle, and return to IDLE.
REQ-026 SHALL ignore start while busy and SHALL NOT re-capture base_addr or word_count.
REQ-027 SHALL accept start in IDLE the cycle after done.

Reset
REQ-028 On rst, SHALL enter IDLE.
REQ-029 On rst, SHALL drive busy=0, done=0, tx_send=0, tx_byte=0, mem_addr=0, and clear the byte index, count and checksum.
REQ-030 On rst mid-dump, SHALL abort immediately with no done pulse, and SHALL ignore a tx_done that arrives after the reset.

Configuration
REQ-031 With macro MEM_UART_CHECKSUM_EN defined, SHALL accumulate the mod-256 sum of all sent data bytes.
REQ-032 With MEM_UART_CHECKSUM_EN defined, the CSUM state SHALL send one extra byte equal to (-sum) mod 256 using the SEND/WAIT_TX handshake, then go to FIN.
REQ-033 With MEM_UART_CHECKSUM_EN defined and word_count == 0, SHALL send a checksum byte of 0x00.
REQ-034 Without MEM_UART_CHECKSUM_EN, SHALL omit the CSUM state and the accumulator, and SHALL go directly to FIN.

Structure
REQ-035 Package mem_uart_pkg SHALL hold the state enum typedef and the function bytes_per_word(WORD_W).
REQ-036 Sub-module mem_uart_bytesel SHALL hold the combinational byte selection (word, index, BIG_ENDIAN -> byte).

Verification
REQ-037 Scenario: WORD_W=32, BIG_ENDIAN=0, ROM[5]=0x11223344, base 5, count 1 -> bytes 44 33 22 11, then done.
REQ-038 Scenario: BIG_ENDIAN=1, same ROM content -> bytes 11 22 33 44.
REQ-039 Scenario: ADDR_W=4, base 15, count 2 -> reads address 15 then 0.
REQ-040 Scenario: count 0 -> no tx_send, done pulses 2 cycles after start.
REQ-041 Scenario: start pulsed while busy, and tx_done held low for 1000 cycles -> no new capture, tx_send pulsed once, tx_byte stable.
REQ-042 Scenario: MEM_UART_CHECKSUM_EN with word 0x01020304 -> 5th byte is 0xF6; rst during the 2nd byte -> IDLE, busy=0, no done.
